me_mem_loader: RTL and testbench

ME_MEM_LOADER -- requirements
Module: me_mem_loader

---
 rtl/me_mem_loader.sv | 132 +++++++++++++
 tb/tb_me_mem_loader.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/me_mem_loader.sv
// Pixel byte-stream loader for the motion-estimation template-block and
// search-window memories. Packs four bytes per 32-bit word (little-endian,
// bank A in the low byte) and writes the template block first, then the
// search window, signalling done when both are full.
module me_mem_loader #(
  parameter int unsigned TB_AW = 6,
  parameter int unsigned SW_AW = 10
) (
  input  logic             clk,
  input  logic             RSTN,
  input  logic             start,
  input  logic             abort,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             tb_we,
  output logic [TB_AW-1:0] tb_waddr,
  output logic [31:0]      tb_wdata,
  output logic             sw_we,
  output logic [SW_AW-1:0] sw_waddr,
  output logic [31:0]      sw_wdata,
  output logic             busy,
  output logic             done
);

  localparam int unsigned WCW = (TB_AW > SW_AW) ? TB_AW : SW_AW;
  localparam logic [WCW-1:0] TB_LAST = WCW'((64'd1 << TB_AW) - 64'd1);
  localparam logic [WCW-1:0] SW_LAST = WCW'((64'd1 << SW_AW) - 64'd1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD_TB = 2'd1,
    LOAD_SW = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [1:0]       byte_cnt;
  logic [WCW-1:0]   word_cnt;
  logic [23:0]      pack;
  logic             accept_c;
  logic             word_end_c;
  logic             write_c;
  logic             phase_change_c;

  // Ready is a pure decode of the loading states so it never bubbles mid-phase.
  assign in_ready = (state == LOAD_TB) || (state == LOAD_SW);

  // State register.
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake decode; abort overrides every other transition.
  always_comb begin
    next_state     = state;
    accept_c       = in_valid && in_ready;
    word_end_c     = accept_c && (byte_cnt == 2'd3);
    write_c        = word_end_c && !abort;
    phase_change_c = 1'b0;
    case (state)
      IDLE: begin
        if (start) next_state = LOAD_TB;
      end
      LOAD_TB: begin
        if (word_end_c && (word_cnt == TB_LAST)) next_state = LOAD_SW;
      end
      LOAD_SW: begin
        if (word_end_c && (word_cnt == SW_LAST)) next_state = DONE;
      end
      DONE: begin
        if (start) next_state = LOAD_TB;
      end
      default: next_state = IDLE;
    endcase
    if (abort) next_state = IDLE;
    phase_change_c = (next_state != state);
  end

  // Byte packing, word counting and registered write ports.
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      byte_cnt <= 2'd0;
      word_cnt <= '0;
      pack     <= 24'd0;
      tb_we    <= 1'b0;
      tb_waddr <= '0;
      tb_wdata <= 32'd0;
      sw_we    <= 1'b0;
      sw_waddr <= '0;
      sw_wdata <= 32'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      tb_we <= 1'b0;
      sw_we <= 1'b0;
      busy  <= (next_state == LOAD_TB) || (next_state == LOAD_SW);
      done  <= (next_state == DONE);

      if (abort) begin
        byte_cnt <= 2'd0;
      end else if (accept_c) begin
        byte_cnt <= byte_cnt + 2'd1;
        pack     <= {in_data, pack[23:8]};
      end

      if (phase_change_c) begin
        word_cnt <= '0;
      end else if (write_c) begin
        word_cnt <= word_cnt + WCW'(1);
      end

      if (write_c) begin
        if (state == LOAD_TB) begin
          tb_we    <= 1'b1;
          tb_waddr <= word_cnt[TB_AW-1:0];
          tb_wdata <= {in_data, pack};
        end else begin
          sw_we    <= 1'b1;
          sw_waddr <= word_cnt[SW_AW-1:0];
          sw_wdata <= {in_data, pack};
        end
      end
    end
  end

endmodule

// File: tb/tb_me_mem_loader.sv
// Directed bench for me_mem_loader: cycle vectors for reset/abort handshakes,
// then full, throttled, restarted and reset-interrupted load sessions.
module tb_me_mem_loader;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic        abort;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        tb_we;
  logic [5:0]  tb_waddr;
  logic [31:0] tb_wdata;
  logic        sw_we;
  logic [9:0]  sw_waddr;
  logic [31:0] sw_wdata;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;

  me_mem_loader #(.TB_AW(6), .SW_AW(10)) dut (
    .clk(clk), .RSTN(rstn), .start(start), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .tb_we(tb_we), .tb_waddr(tb_waddr), .tb_wdata(tb_wdata),
    .sw_we(sw_we), .sw_waddr(sw_waddr), .sw_wdata(sw_wdata),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Memory model and strobe monitor, sampled on the falling edge.
  logic [31:0] tb_mem [64];
  logic [31:0] sw_mem [1024];
  int          tb_cnt = 0;
  int          sw_cnt = 0;
  int          overlap = 0;
  int          order_err = 0;
  logic [5:0]  last_tb = '0;
  logic [9:0]  last_sw = '0;

  always @(negedge clk) begin
    if (tb_we && sw_we) overlap++;
    if (tb_we) begin
      tb_mem[tb_waddr] = tb_wdata;
      tb_cnt++;
      if (tb_waddr != 6'd0 && tb_waddr != last_tb + 6'd1) order_err++;
      last_tb = tb_waddr;
    end
    if (sw_we) begin
      sw_mem[sw_waddr] = sw_wdata;
      sw_cnt++;
      if (sw_waddr != 10'd0 && sw_waddr != last_sw + 10'd1) order_err++;
      last_sw = sw_waddr;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Word made of stream bytes idx..idx+3, byte k in bits [8k+7:8k].
  function automatic logic [31:0] exp_word(input int idx);
    return {8'(idx + 3), 8'(idx + 2), 8'(idx + 1), 8'(idx)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stream n bytes of value (base+i); optionally throttled; optional start pulse at byte start_at.
  task automatic stream(input int n, input int base, input bit thr, input int start_at,
                        output int stalls, output int cycles);
    int  i;
    bit  rdy;
    i = 0;
    stalls = 0;
    cycles = 0;
    while (i < n) begin
      in_valid = thr ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = in_valid ? 8'(base + i) : 8'($urandom);
      start    = (i == start_at);
      rdy      = in_ready;
      if (in_valid && !rdy) stalls++;
      tick();
      cycles++;
      if (in_valid && rdy) i++;
      if (cycles > 20000) begin
        n_cmp++;
        n_bad++;
        $display("FAIL stream_budget: accepted=%0d required=%0d", i, n);
        break;
      end
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  typedef struct {
    logic        rstn, start, abort, valid;
    logic [7:0]  data;
    logic        rdy, busy, done, we;
    logic [5:0]  addr;
    logic [31:0] wdata;
  } vec_t;

  vec_t vecs [13];

  initial begin
    int stalls, cycles, err, tb0, sw0;

    rstn = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = 8'h00;

    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'hA0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 32'h0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 32'h0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'hA2, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 32'h0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'hA3, 1'b1, 1'b1, 1'b0, 1'b1, 6'd0, 32'hA3A2A1A0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'hA4, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 32'hA3A2A1A0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 32'hA3A2A1A0};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 32'hA3A2A1A0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 32'hA3A2A1A0};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 32'hA3A2A1A0};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 32'hA3A2A1A0};

    #2;
    // Reset, first word, abort after six bytes, abort beating start, restart.
    for (int v = 0; v < 13; v++) begin
      rstn = vecs[v].rstn; start = vecs[v].start; abort = vecs[v].abort;
      in_valid = vecs[v].valid; in_data = vecs[v].data;
      tick();
      check($sformatf("v%0d_in_ready", v), 32'(in_ready), 32'(vecs[v].rdy));
      check($sformatf("v%0d_busy", v), 32'(busy), 32'(vecs[v].busy));
      check($sformatf("v%0d_done", v), 32'(done), 32'(vecs[v].done));
      check($sformatf("v%0d_tb_we", v), 32'(tb_we), 32'(vecs[v].we));
      check($sformatf("v%0d_sw_we", v), 32'(sw_we), 32'h0);
      check($sformatf("v%0d_tb_waddr", v), 32'(tb_waddr), 32'(vecs[v].addr));
      check($sformatf("v%0d_tb_wdata", v), tb_wdata, vecs[v].wdata);
    end
    start = 1'b0; abort = 1'b0; in_valid = 1'b0;

    // Abort coincident with the 4th byte of word 5.
    tb0 = tb_cnt;
    stream(23, 0, 1'b0, -1, stalls, cycles);
    in_valid = 1'b1; in_data = 8'h17; abort = 1'b1;
    tick();
    abort = 1'b0; in_valid = 1'b0;
    check("abort4_tb_we", 32'(tb_we), 32'h0);
    check("abort4_in_ready", 32'(in_ready), 32'h0);
    check("abort4_busy", 32'(busy), 32'h0);
    check("abort4_tb_waddr", 32'(tb_waddr), 32'd4);
    check("abort4_tb_wdata", tb_wdata, 32'h13121110);
    repeat (5) tick();
    check("abort4_strobes", 32'(tb_cnt - tb0), 32'd5);

    // Full back-to-back load with an ignored start during LOAD_SW.
    start = 1'b1; tick(); start = 1'b0;
    tb0 = tb_cnt; sw0 = sw_cnt;
    stream(4352, 0, 1'b0, 1000, stalls, cycles);
    check("full_stalls", 32'(stalls), 32'd0);
    check("full_cycles", 32'(cycles), 32'd4352);
    check("full_last_sw_we", 32'(sw_we), 32'h1);
    check("full_last_sw_waddr", 32'(sw_waddr), 32'd1023);
    check("full_last_sw_wdata", sw_wdata, 32'hFFFEFDFC);
    check("full_done_first", 32'(done), 32'h1);
    tick();
    check("full_sw_we_drop", 32'(sw_we), 32'h0);
    check("full_done_hold", 32'(done), 32'h1);
    check("full_busy", 32'(busy), 32'h0);
    check("full_tb_strobes", 32'(tb_cnt - tb0), 32'd64);
    check("full_sw_strobes", 32'(sw_cnt - sw0), 32'd1024);
    check("full_tb_word0", tb_mem[0], 32'h03020100);
    check("full_sw_word0", sw_mem[0], 32'h03020100);
    err = 0;
    for (int a = 0; a < 64; a++) if (tb_mem[a] !== exp_word(4 * a)) err++;
    for (int a = 0; a < 1024; a++) if (sw_mem[a] !== exp_word(256 + 4 * a)) err++;
    check("full_mem_errors", 32'(err), 32'd0);

    // Start from DONE restarts template writes at address 0.
    start = 1'b1; tick(); start = 1'b0;
    check("restart_done", 32'(done), 32'h0);
    check("restart_busy", 32'(busy), 32'h1);
    stream(4, 8'h40, 1'b0, -1, stalls, cycles);
    check("restart_tb_we", 32'(tb_we), 32'h1);
    check("restart_tb_waddr", 32'(tb_waddr), 32'd0);
    check("restart_tb_wdata", tb_wdata, 32'h43424140);
    abort = 1'b1; tick(); abort = 1'b0;

    // Throttled load with a different byte offset.
    start = 1'b1; tick(); start = 1'b0;
    tb0 = tb_cnt; sw0 = sw_cnt;
    stream(4352, 8'h37, 1'b1, -1, stalls, cycles);
    check("thr_stalls", 32'(stalls), 32'd0);
    tick();
    check("thr_done", 32'(done), 32'h1);
    check("thr_tb_strobes", 32'(tb_cnt - tb0), 32'd64);
    check("thr_sw_strobes", 32'(sw_cnt - sw0), 32'd1024);
    err = 0;
    for (int a = 0; a < 64; a++) if (tb_mem[a] !== exp_word(8'h37 + 4 * a)) err++;
    for (int a = 0; a < 1024; a++) if (sw_mem[a] !== exp_word(8'h37 + 256 + 4 * a)) err++;
    check("thr_mem_errors", 32'(err), 32'd0);

    // Reset asserted mid-LOAD_SW.
    start = 1'b1; tick(); start = 1'b0;
    stream(356, 0, 1'b0, -1, stalls, cycles);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_we", {30'd0, tb_we, sw_we}, 32'h0);
    check("rst_sw_waddr", 32'(sw_waddr), 32'h0);
    check("rst_tb_waddr", 32'(tb_waddr), 32'h0);
    check("rst_wdata", tb_wdata | sw_wdata, 32'h0);
    tick();
    rstn = 1'b1;
    tb0 = tb_cnt; sw0 = sw_cnt;
    in_valid = 1'b1; in_data = 8'h55;
    repeat (10) tick();
    in_valid = 1'b0;
    check("postrst_in_ready", 32'(in_ready), 32'h0);
    check("postrst_busy", 32'(busy), 32'h0);
    check("postrst_strobes", 32'((tb_cnt - tb0) + (sw_cnt - sw0)), 32'd0);

    check("no_overlap", 32'(overlap), 32'd0);
    check("addr_order", 32'(order_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
